spi_flash_erase_ctrl: RTL

Parametrised SPI NOR-flash erase controller for the serial-flash path. One `start` pulse runs the full erase: WREN (0x06), then either Bulk Erase (0xC7) or Sector Erase (0xD8 + 24-bit address). It then polls RDSR (0x05) until WIP clears or a poll budget expires. It drives the flash pins directly and reports `busy`, `done` and `timeout` to the upstream control logic, for example a debounced key edge or a command FSM.

---
 rtl/spi_flash_pkg.sv | 28 ++
 rtl/spi_flash_erase_ctrl_if.sv | 26 ++
 rtl/spi_shift_engine.sv | 91 +++++++++
 rtl/spi_flash_erase_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and frame helpers for the SPI NOR erase controller.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_BE   = 8'hC7;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int FRAME_BITS = 32;
  localparam int NBITS_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREN  = 3'd1,
    ST_GAP_A = 3'd2,
    ST_ERASE = 3'd3,
    ST_GAP_B = 3'd4,
    ST_POLL  = 3'd5,
    ST_GAP_P = 3'd6,
    ST_FIN   = 3'd7
  } state_e;

  // Frames are left-aligned: the opcode always leaves first.
  function automatic logic [31:0] frame_word(input logic [7:0] op, input logic [23:0] tail);
    return {op, tail};
  endfunction

endpackage

// File: rtl/spi_flash_erase_ctrl_if.sv
// Upstream request/status handshake plus the flash pins, bundled for the erase controller.
interface spi_flash_erase_ctrl_if;

  logic        start;
  logic        sector_mode;
  logic [23:0] addr;
  logic        busy;
  logic        done;
  logic        timeout;

  logic        cs_n;
  logic        sck;
  logic        mosi;
  logic        miso;

  modport master (
    output start, sector_mode, addr, miso,
    input  busy, done, timeout, cs_n, sck, mosi
  );

  modport slave (
    input  start, sector_mode, addr, miso,
    output busy, done, timeout, cs_n, sck, mosi
  );

endinterface

// File: rtl/spi_shift_engine.sv
// Mode-3 SPI frame engine: one go pulse shifts nbits of tx_data MSB-first and samples miso.
module spi_shift_engine #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               go,
  input  logic [$clog2(MAX_BITS + 1) - 1:0]  nbits,
  input  logic [MAX_BITS - 1:0]              tx_data,
  input  logic                               miso,
  output logic                               cs_n,
  output logic                               sck,
  output logic                               mosi,
  output logic [7:0]                         rx_data,
  output logic                               done
);

  localparam int NBW = $clog2(MAX_BITS + 1);
  localparam int HW  = NBW + 1;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic                active_r;
  logic [DW-1:0]       div_r;
  logic [HW-1:0]       half_r;
  logic [HW-1:0]       last_half_r;
  logic [MAX_BITS-1:0] shift_r;
  logic [7:0]          rx_r;
  logic                cs_n_r;
  logic                sck_r;
  logic                mosi_r;

  logic                div_wrap_s;
  logic                last_half_s;
  logic [HW-1:0]       half_nxt_s;

  assign div_wrap_s  = (div_r == DIV_LAST);
  assign last_half_s = (half_r == last_half_r);
  assign half_nxt_s  = half_r + HW'(1'b1);

  assign done    = active_r & div_wrap_s & last_half_s;
  assign cs_n    = cs_n_r;
  assign sck     = sck_r;
  assign mosi    = mosi_r;
  assign rx_data = rx_r;

  // Half-period sequencer: odd halves drive SCK low and present data, even halves raise SCK and sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r    <= 1'b0;
      div_r       <= '0;
      half_r      <= '0;
      last_half_r <= '0;
      shift_r     <= '0;
      rx_r        <= 8'h00;
      cs_n_r      <= 1'b1;
      sck_r       <= 1'b1;
      mosi_r      <= 1'b0;
    end else if (!active_r) begin
      if (go) begin
        active_r    <= 1'b1;
        cs_n_r      <= 1'b0;
        div_r       <= '0;
        half_r      <= '0;
        last_half_r <= {nbits, 1'b0};
        shift_r     <= tx_data;
      end
    end else if (div_wrap_s) begin
      div_r <= '0;
      if (last_half_s) begin
        // Trailing half keeps cs_n low one more half-period after the final rising edge.
        active_r <= 1'b0;
        cs_n_r   <= 1'b1;
      end else begin
        half_r <= half_nxt_s;
        if (half_nxt_s[0]) begin
          sck_r   <= 1'b0;
          mosi_r  <= shift_r[MAX_BITS-1];
          shift_r <= {shift_r[MAX_BITS-2:0], 1'b0};
        end else begin
          sck_r <= 1'b1;
          rx_r  <= {rx_r[6:0], miso};
        end
      end
    end else begin
      div_r <= div_r + DW'(1'b1);
    end
  end

endmodule

// File: rtl/spi_flash_erase_ctrl.sv
// Erase sequencer: WREN, bulk or sector erase, then RDSR polling until WIP clears or the budget runs out.
module spi_flash_erase_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 8,
  parameter int POLL_MAX = 65535
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  spi_flash_erase_ctrl_if.slave  bus
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP - 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  state_e               state_r;
  logic                 sector_r;
  logic [23:0]          addr_r;
  logic [GW-1:0]        gap_cnt_r;
  logic [PW-1:0]        poll_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 timeout_r;

  logic                 go_s;
  logic [NBITS_W-1:0]   nbits_s;
  logic [FRAME_BITS-1:0] tx_s;
  logic                 gap_end_s;
  logic [PW-1:0]        poll_nxt_s;
  logic                 eng_done_s;
  logic [7:0]           rx_s;
  logic                 cs_n_s;
  logic                 sck_s;
  logic                 mosi_s;
  logic                 unused_status_s;

  assign gap_end_s       = (gap_cnt_r == GAP_LAST);
  assign poll_nxt_s      = (poll_cnt_r == POLL_LIMIT) ? poll_cnt_r : poll_cnt_r + PW'(1'b1);
  assign unused_status_s = ^rx_s[7:1];

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.timeout = timeout_r;
  assign bus.cs_n    = cs_n_s;
  assign bus.sck     = sck_s;
  assign bus.mosi    = mosi_s;

  // Frame launch: issued from IDLE or the last gap cycle so cs_n falls on the very next cycle.
  always_comb begin
    go_s    = 1'b0;
    nbits_s = 6'd8;
    tx_s    = frame_word(OP_WREN, 24'h000000);
    case (state_r)
      ST_IDLE: begin
        go_s = bus.start;
      end
      ST_GAP_A: begin
        go_s = gap_end_s;
        if (sector_r) begin
          nbits_s = 6'd32;
          tx_s    = frame_word(OP_SE, addr_r);
        end else begin
          nbits_s = 6'd8;
          tx_s    = frame_word(OP_BE, 24'h000000);
        end
      end
      ST_GAP_B, ST_GAP_P: begin
        go_s    = gap_end_s;
        nbits_s = 6'd16;
        tx_s    = frame_word(OP_RDSR, 24'h000000);
      end
      default: begin
        go_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with gap/poll counters, request latches and registered status outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      sector_r   <= 1'b0;
      addr_r     <= 24'h000000;
      gap_cnt_r  <= '0;
      poll_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            sector_r   <= bus.sector_mode;
            addr_r     <= bus.addr;
            timeout_r  <= 1'b0;
            poll_cnt_r <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_WREN;
          end
        end
        ST_WREN: begin
          if (eng_done_s) begin
            gap_cnt_r <= '0;
            state_r   <= ST_GAP_A;
          end
        end
        ST_GAP_A: begin
          if (gap_end_s) begin
            state_r <= ST_ERASE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1'b1);
          end
        end
        ST_ERASE: begin
          if (eng_done_s) begin
            gap_cnt_r <= '0;
            state_r   <= ST_GAP_B;
          end
        end
        ST_GAP_B, ST_GAP_P: begin
          if (gap_end_s) begin
            state_r <= ST_POLL;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1'b1);
          end
        end
        ST_POLL: begin
          if (eng_done_s) begin
            poll_cnt_r <= poll_nxt_s;
            // WIP clear wins over an exhausted budget on the same poll.
            if (!rx_s[0]) begin
              state_r <= ST_FIN;
            end else if (poll_nxt_s == POLL_LIMIT) begin
              timeout_r <= 1'b1;
              state_r   <= ST_FIN;
            end else begin
              gap_cnt_r <= '0;
              state_r   <= ST_GAP_P;
            end
          end
        end
        ST_FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  spi_shift_engine #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BITS (FRAME_BITS)
  ) u_engine (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .go      (go_s),
    .nbits   (nbits_s),
    .tx_data (tx_s),
    .miso    (bus.miso),
    .cs_n    (cs_n_s),
    .sck     (sck_s),
    .mosi    (mosi_s),
    .rx_data (rx_s),
    .done    (eng_done_s)
  );

endmodule
